// File: rtl/alu_accum_seq_if.sv
// alu_accum_seq_if: control, operand and status bundle for alu_accum_seq
interface alu_accum_seq_if #(parameter int WIDTH = 8);
    logic on;
    logic start;
    logic [1:0] in_sel;
    logic [2:0] op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] acc;
    logic busy;
    logic done;
    logic overflow;
    logic [1:0] state;
    modport master (
        output on, start, in_sel, op, operand_a, operand_b,
        input acc, busy, done, overflow, state
    );
    modport slave (
        input on, start, in_sel, op, operand_a, operand_b,
        output acc, busy, done, overflow, state
    );
endinterface

// File: rtl/alu_accum_seq.sv
// alu_accum_seq: accumulator ALU with OFF/READY/RUN/ERROR control FSM and iterative shift-add multiplier
module alu_accum_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    alu_accum_seq_if.slave bus
);
    typedef enum logic [1:0] {OFF = 2'b00, READY = 2'b01, RUN = 2'b10, ERROR = 2'b11} state_t;
    localparam logic [2:0] OP_MUL = 3'b110;
    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, a_lo, a_sel, fin_res;
    logic [2*WIDTH-1:0] a_q, a_d, prod_q, prod_d, prod_sum;
    logic [2:0] op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d, ov_q, ov_d;
    logic [WIDTH:0] res;
    logic accept, is_mul, fin, fin_ov;
    assign a_lo = a_q[WIDTH-1:0];
    assign a_sel = bus.in_sel == 2'b01 ? bus.operand_a : bus.in_sel == 2'b10 ? '0 : acc_q;
    assign accept = state_q == READY && bus.on && bus.start;
    assign is_mul = op_q == OP_MUL;
    assign prod_sum = prod_q + (b_q[0] ? a_q : '0);
    assign fin = state_q == RUN && (!is_mul || cnt_q == CNT_W'(WIDTH - 1));
    assign fin_res = is_mul ? prod_sum[WIDTH-1:0] : res[WIDTH-1:0];
    assign fin_ov = is_mul ? |prod_sum[2*WIDTH-1:WIDTH] : res[WIDTH];
    // res[WIDTH] carries the ADD carry / SUB borrow and is zero for every other op
    always_comb begin
        res = '0;
        case (op_q)
            3'b000: res = {1'b0, a_lo & b_q};
            3'b001: res = {1'b0, a_lo | b_q};
            3'b010: res = {1'b0, a_lo ^ b_q};
            3'b011: res = {1'b0, ~a_lo};
            3'b100: res = {1'b0, a_lo} + {1'b0, b_q};
            3'b101: res = {1'b0, a_lo} - {1'b0, b_q};
            default: res = {1'b0, b_q};
        endcase
    end
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        prod_d = prod_q;
        cnt_d = cnt_q;
        ov_d = ov_q;
        done_d = fin;
        case (state_q)
            OFF: state_d = bus.on ? READY : OFF;
            READY: state_d = !bus.on ? OFF : bus.start ? RUN : READY;
            RUN: state_d = !fin ? RUN : fin_ov ? ERROR : READY;
            default: state_d = READY;
        endcase
        if (accept) begin
            a_d = {{WIDTH{1'b0}}, a_sel};
            b_d = bus.operand_b;
            op_d = bus.op;
            prod_d = '0;
            cnt_d = '0;
            ov_d = 1'b0;
        end
        if (state_q == RUN) begin
            a_d = a_q << 1;
            b_d = b_q >> 1;
            prod_d = prod_sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (fin) begin
            acc_d = fin_res;
            ov_d = fin_ov;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= READY;
            acc_q <= '0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            prod_q <= '0;
            cnt_q <= '0;
            ov_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            prod_q <= prod_d;
            cnt_q <= cnt_d;
            ov_q <= ov_d;
            done_q <= done_d;
        end
    end
    assign bus.acc = acc_q;
    assign bus.busy = state_q == RUN;
    assign bus.done = done_q;
    assign bus.overflow = ov_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_alu_accum_seq.sv
// tb_alu_accum_seq: vector table plus corner sequences, checked through a done-driven scoreboard
module tb_alu_accum_seq;
    localparam int W = 8;
    localparam logic [1:0] S_OFF = 2'b00, S_READY = 2'b01, S_RUN = 2'b10, S_ERR = 2'b11;
    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eacc;
        logic eov;
    } vec_t;
    typedef struct packed {
        logic [W-1:0] acc;
        logic ov;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];
    vec_t v[15];
    alu_accum_seq_if #(.WIDTH(W)) bus ();
    alu_accum_seq #(.WIDTH(W), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc", 32'(bus.acc), 32'(e.acc));
                chk("overflow", 32'(bus.overflow), 32'(e.ov));
                chk("done_state", 32'(bus.state), e.ov ? 32'(S_ERR) : 32'(S_READY));
            end
        end
    end
    task automatic do_op(input vec_t t);
        int k, bc, lat;
        lat = (t.op == 3'b110) ? W + 1 : 2;
        bus.in_sel = t.sel;
        bus.op = t.op;
        bus.operand_a = t.a;
        bus.operand_b = t.b;
        bus.start = 1'b1;
        sb.push_back('{acc: t.eacc, ov: t.eov});
        cyc();
        bus.start = 1'b0;
        k = 1;
        bc = 0;
        @(negedge clk);
        chk("ov_clear_at_accept", 32'(bus.overflow), 32'd0);
        while (!bus.done && k < 30) begin
            bc += int'(bus.busy);
            cyc();
            k++;
            @(negedge clk);
        end
        chk("latency", 32'(k), 32'(lat));
        chk("busy_cycles", 32'(bc), 32'(lat - 1));
        cyc();
    endtask
    initial begin
        v = '{
            '{2'b01, 3'b100, 8'd200, 8'd100, 8'd44, 1'b1},
            '{2'b01, 3'b110, 8'd15, 8'd17, 8'd255, 1'b0},
            '{2'b01, 3'b110, 8'd16, 8'd16, 8'd0, 1'b1},
            '{2'b01, 3'b100, 8'd5, 8'd3, 8'd8, 1'b0},
            '{2'b00, 3'b101, 8'd99, 8'd10, 8'd254, 1'b1},
            '{2'b00, 3'b011, 8'd99, 8'd0, 8'd1, 1'b0},
            '{2'b01, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0},
            '{2'b00, 3'b001, 8'h00, 8'h0F, 8'h3F, 1'b0},
            '{2'b00, 3'b010, 8'h00, 8'hFF, 8'hC0, 1'b0},
            '{2'b11, 3'b111, 8'h00, 8'h5A, 8'h5A, 1'b0},
            '{2'b10, 3'b100, 8'd77, 8'd7, 8'd7, 1'b0},
            '{2'b11, 3'b100, 8'd0, 8'd250, 8'd1, 1'b1},
            '{2'b01, 3'b101, 8'd100, 8'd100, 8'd0, 1'b0},
            '{2'b01, 3'b110, 8'd255, 8'd255, 8'd1, 1'b1},
            '{2'b00, 3'b110, 8'd0, 8'd2, 8'd2, 1'b0}
        };
        rst = 1'b1;
        bus.on = 1'b1;
        bus.start = 1'b0;
        bus.in_sel = 2'b00;
        bus.op = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'(S_READY));
        chk("rst_acc", 32'(bus.acc), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ov", 32'(bus.overflow), 32'd0);
        cyc();
        bus.on = 1'b0;
        cyc();
        @(negedge clk);
        chk("off_state", 32'(bus.state), 32'(S_OFF));
        bus.start = 1'b1;
        cyc();
        @(negedge clk);
        chk("off_ignores_start", 32'(bus.state), 32'(S_OFF));
        bus.start = 1'b0;
        bus.on = 1'b1;
        cyc();
        @(negedge clk);
        chk("on_ready", 32'(bus.state), 32'(S_READY));
        cyc();
        for (int i = 0; i < 15; i++) do_op(v[i]);
        // start pulses in RUN and ERROR must not be accepted
        bus.in_sel = 2'b01;
        bus.op = 3'b100;
        bus.operand_a = 8'd200;
        bus.operand_b = 8'd100;
        bus.start = 1'b1;
        sb.push_back('{acc: 8'd44, ov: 1'b1});
        cyc();
        bus.operand_b = 8'd1;
        @(negedge clk);
        chk("ign_run_busy", 32'(bus.busy), 32'd1);
        cyc();
        @(negedge clk);
        chk("ign_err_state", 32'(bus.state), 32'(S_ERR));
        cyc();
        bus.start = 1'b0;
        @(negedge clk);
        chk("ign_ready_state", 32'(bus.state), 32'(S_READY));
        repeat (3) cyc();
        @(negedge clk);
        chk("ign_acc_kept", 32'(bus.acc), 32'd44);
        chk("ign_idle", 32'(bus.state), 32'(S_READY));
        cyc();
        // start held: accepts at N and N+2
        bus.in_sel = 2'b01;
        bus.op = 3'b100;
        bus.operand_a = 8'd1;
        bus.operand_b = 8'd1;
        bus.start = 1'b1;
        sb.push_back('{acc: 8'd2, ov: 1'b0});
        sb.push_back('{acc: 8'd2, ov: 1'b0});
        repeat (3) cyc();
        bus.start = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("b2b_acc", 32'(bus.acc), 32'd2);
        cyc();
        // reset in the middle of a MUL
        do_op('{2'b01, 3'b111, 8'd0, 8'd77, 8'd77, 1'b0});
        bus.in_sel = 2'b01;
        bus.op = 3'b110;
        bus.operand_a = 8'd9;
        bus.operand_b = 8'd9;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("mul_run_acc_hold", 32'(bus.acc), 32'd77);
        chk("mul_run_busy", 32'(bus.busy), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(bus.state), 32'(S_READY));
        chk("abort_acc", 32'(bus.acc), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        cyc();
        do_op('{2'b01, 3'b110, 8'd9, 8'd9, 8'd81, 1'b0});
        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
